// File: rtl/sevseg_bcd_scanner.sv
// Sequential double-dabble BCD converter feeding a four-digit, active-low 7-segment scanner.
// Optional macro SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sevseg_bcd_scanner #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        dp_mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        upd
);

    typedef enum logic [1:0] {StLoad, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] bcd_q, bcd_d;
    logic        frac_q, frac_d;
    logic        mode_q, mode_d;
    logic [15:0] dig_q, dig_d;
    logic [3:0]  blank_q, blank_d;
    logic        dmode_q, dmode_d;
    logic        upd_q, upd_d;

    logic [15:0] half;
    logic [15:0] adj;
    logic [15:0] res;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             wrap;
    logic [3:0]       cur_dig;

    assign half = {1'b0, value[15:1]};

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // In dp mode the integer part sits in d3..d1 and d0 holds the half-unit digit.
    always_comb begin
        if (mode_q) begin
            res = {bcd_q[11:0], (frac_q ? 4'd5 : 4'd0)};
        end else begin
            res = bcd_q;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        opnd_d  = opnd_q;
        bcd_d   = bcd_q;
        frac_d  = frac_q;
        mode_d  = mode_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        dmode_d = dmode_q;
        upd_d   = 1'b0;
        unique case (state_q)
            StLoad: begin
                mode_d = dp_mode;
                frac_d = value[0];
                if (dp_mode) begin
                    opnd_d = (half > 16'd999) ? 16'd999 : half;
                end else begin
                    opnd_d = (value > 16'd9999) ? 16'd9999 : value;
                end
                bcd_d   = '0;
                step_d  = '0;
                state_d = StShift;
            end
            StShift: begin
                bcd_d  = {adj[14:0], opnd_q[15]};
                opnd_d = {opnd_q[14:0], 1'b0};
                step_d = step_q + 4'd1;
                if (step_q == 4'd15) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                dig_d   = res;
                dmode_d = mode_q;
                upd_d   = 1'b1;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
                blank_d[3] = (res[15:12] == 4'd0);
                blank_d[2] = blank_d[3] && (res[11:8] == 4'd0);
                blank_d[1] = !mode_q && blank_d[2] && (res[7:4] == 4'd0);
                blank_d[0] = 1'b0;
`else
                blank_d = '0;
`endif
                state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            step_q  <= '0;
            opnd_q  <= '0;
            bcd_q   <= '0;
            frac_q  <= 1'b0;
            mode_q  <= 1'b0;
            dig_q   <= '0;
            blank_q <= '0;
            dmode_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            opnd_q  <= opnd_d;
            bcd_q   <= bcd_d;
            frac_q  <= frac_d;
            mode_q  <= mode_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            dmode_q <= dmode_d;
            upd_q   <= upd_d;
        end
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    assign wrap    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign cur_dig = dig_q[4*idx_q +: 4];

    // an, seg and dp are all registered from the same index so they switch together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap) begin
                idx_q <= idx_q + 2'd1;
            end
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= blank_q[idx_q] ? 7'b1111111 : enc(cur_dig);
            dp_q  <= !(dmode_q && (idx_q == 2'd1));
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign upd = upd_q;

endmodule

// File: tb/tb_sevseg_bcd_scanner.sv
// Scoreboard bench for sevseg_bcd_scanner: stimulus queues expected digits, a monitor
// checks every scan slot after each upd pulse. Honours SEVSEG_LEADING_ZERO_BLANK_EN.
module tb_sevseg_bcd_scanner;

    typedef struct packed {
        logic [15:0] dig;   // d3..d0 nibbles, 4'hF = blank
        logic        dpm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic        dp_mode = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        upd;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int upds = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sevseg_bcd_scanner #(
        .REFRESH_DIV(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .dp_mode(dp_mode),
        .an(an),
        .seg(seg),
        .dp(dp),
        .upd(upd)
    );

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: each upd pops one expectation and checks the following full scan.
    exp_t       mon_e;
    int         mon_idx;
    int         mon_prev;
    logic [3:0] mon_an;
    logic [3:0] mon_nib;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (upd === 1'b1) begin
                upds++;
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    mon_prev = -1;
                    for (int s = 0; s < 16; s++) begin
                        @(negedge clk);
                        if (s == 0) check("upd_one_cycle", 32'(upd), 32'd0);
                        mon_idx = 0;
                        for (int b = 3; b >= 0; b--) begin
                            if (an[b] == 1'b0) mon_idx = b;
                        end
                        mon_an = 4'b0001 << mon_idx;
                        mon_an = ~mon_an;
                        check("an_onehot", 32'(an), 32'(mon_an));
                        mon_nib = mon_e.dig[4*mon_idx +: 4];
                        check("seg_dp", 32'({seg, dp}),
                              32'({enc(mon_nib), !(mon_e.dpm && mon_idx == 1)}));
                        if (mon_prev >= 0 && mon_idx != mon_prev) begin
                            check("scan_order", 32'(mon_idx), 32'((mon_prev + 1) % 4));
                        end
                        mon_prev = mon_idx;
                    end
                end
            end
        end
    end

    task automatic push(input logic [15:0] plain, input logic [15:0] blanked, input logic dpm);
        exp_t e;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        e.dig = blanked;
`else
        e.dig = plain;
`endif
        e.dpm = dpm;
        sb.push_back(e);
        pushes++;
    endtask

    // Called on the negedge just before a LOAD edge; returns on the negedge before the next one.
    task automatic apply(input logic [15:0] v, input logic dpm,
                         input logic [15:0] plain, input logic [15:0] blanked);
        value = v;
        dp_mode = dpm;
        push(plain, blanked, dpm);
        repeat (18) @(posedge clk);
        @(negedge clk);
    endtask

    // Releases reset and measures the cycles until the first upd.
    task automatic apply_first(input logic [15:0] v, input logic dpm,
                               input logic [15:0] plain, input logic [15:0] blanked,
                               input bit chk_an);
        int n;
        logic [3:0] ea;
        value = v;
        dp_mode = dpm;
        reset = 1'b0;
        push(plain, blanked, dpm);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (chk_an && n <= 16) begin
                ea = 4'b0001 << (((n - 1) / 4) % 4);
                ea = ~ea;
                check("an_step", 32'(an), 32'(ea));
            end
        end while (upd !== 1'b1 && n < 40);
        check("first_upd_latency", 32'(n), 32'd18);
    endtask

    task automatic check_reset_outputs();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_upd", 32'(upd), 32'd0);
    endtask

    // Asserts reset while the next conversion is still in SHIFT, after the monitor's scan window.
    task automatic reset_mid();
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
    endtask

    initial begin : stimulus
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        apply_first(16'd0, 1'b0, 16'h0000, 16'hFFF0, 1'b1);
        apply(16'd1234, 1'b0, 16'h1234, 16'h1234);
        apply(16'd25, 1'b1, 16'h0125, 16'hF125);
        apply(16'd3, 1'b1, 16'h0015, 16'hFF15);
        apply(16'd1, 1'b1, 16'h0005, 16'hFF05);
        apply(16'hFFFF, 1'b0, 16'h9999, 16'h9999);
        apply(16'hFFFF, 1'b1, 16'h9995, 16'h9995);
        apply(16'd1999, 1'b1, 16'h9995, 16'h9995);
        apply(16'd2000, 1'b1, 16'h9990, 16'h9990);
        apply(16'd9999, 1'b0, 16'h9999, 16'h9999);
        apply(16'd10000, 1'b0, 16'h9999, 16'h9999);
        apply(16'd7, 1'b0, 16'h0007, 16'hFFF7);

        // Input changes mid-SHIFT must not reach this conversion.
        value = 16'd100;
        dp_mode = 1'b0;
        push(16'h0100, 16'hF100, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        value = 16'd200;
        repeat (13) @(posedge clk);
        @(negedge clk);
        apply(16'd200, 1'b0, 16'h0200, 16'hF200);

        apply(16'd4321, 1'b0, 16'h4321, 16'h4321);
        reset_mid();
        @(negedge clk);
        check_reset_outputs();
        apply_first(16'd4321, 1'b0, 16'h4321, 16'h4321, 1'b0);

        reset_mid();
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("upd_count", 32'(upds), 32'(pushes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
